// File: rtl/music_streamer_pkg.sv
// Shared types and constants for the music streamer: FSM encoding, tone width, LED map,
// and the tone table contents used to build the tone ROM.
package music_streamer_pkg;

    localparam int TONE_WIDTH   = 24;
    localparam int LED_WIDTH    = 6;
    localparam int LED_PLAYING  = 0;
    localparam int LED_REVERSE  = 1;
    localparam int LED_ADDR_LSB = 2;
    localparam int LED_ADDR_MSB = 5;

    typedef enum logic {
        ST_PLAY   = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    // Half-period for note index idx; never zero, so silence stays distinguishable.
    function automatic logic [TONE_WIDTH-1:0] tone_word(input logic [31:0] idx);
        return TONE_WIDTH'(32'd1000 + idx * 32'd37);
    endfunction

endpackage

// File: rtl/music_streamer_if.sv
// Control pulses in, tone/address/status out; master drives controls, slave is the streamer.
interface music_streamer_if #(
    parameter int ADDR_WIDTH = 10
);
    import music_streamer_pkg::*;

    logic                  play_pause;
    logic                  reverse;
    logic                  tempo_up;
    logic                  tempo_down;
    logic [TONE_WIDTH-1:0] tone;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [LED_WIDTH-1:0]  leds;

    modport master (
        output play_pause, reverse, tempo_up, tempo_down,
        input  tone, rom_addr, leds
    );

    modport slave (
        input  play_pause, reverse, tempo_up, tempo_down,
        output tone, rom_addr, leds
    );

endinterface

// File: rtl/music_streamer_tone_rom.sv
// Tone ROM, 2^ADDR_WIDTH x TONE_WIDTH; synchronous read, 1 cycle latency, no backpressure.
module tone_rom
    import music_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [TONE_WIDTH-1:0] data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [TONE_WIDTH-1:0] rom [DEPTH];
    logic [TONE_WIDTH-1:0] data_d;
    logic [TONE_WIDTH-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = tone_word(32'(i));
    end

    always_comb begin
        data_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/music_streamer.sv
// Steps through the tone ROM at a tempo-controlled rate with play/pause and direction control;
// tone follows rom_addr with 2 cycles latency; control pulses are always accepted (no backpressure).
module music_streamer
    import music_streamer_pkg::*;
#(
    parameter int CYCLES_PER_SECOND = 125_000_000,
    parameter int NOTE_DIV          = 40,
    parameter int TEMPO_STEP        = 125_000,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic              clk,
    input  logic              rst,
    music_streamer_if.slave   bus
);

    localparam logic [31:0] NOTE_LEN_RST = 32'(CYCLES_PER_SECOND / NOTE_DIV);
    localparam logic [31:0] NOTE_LEN_MAX = 32'(2 * CYCLES_PER_SECOND / NOTE_DIV * 4);
    localparam logic [31:0] STEP         = 32'(TEMPO_STEP);
    localparam logic [31:0] STEP_X2      = 32'(2 * TEMPO_STEP);

    state_e                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           note_len_q, note_len_d;
    logic [TONE_WIDTH-1:0] tone_q, tone_d;
    logic [TONE_WIDTH-1:0] rom_data;
    logic [32:0]           len_sum;
    logic                  playing;
    logic [LED_WIDTH-1:0]  led_vec;

    tone_rom #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rom (
        .clk  (clk),
        .addr (addr_q),
        .data (rom_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.play_pause) begin
            state_d = (state_q == ST_PLAY) ? ST_PAUSED : ST_PLAY;
        end
    end

    always_comb begin
        playing                               = (state_q == ST_PLAY);
        led_vec                               = '0;
        led_vec[LED_PLAYING]                  = playing;
        led_vec[LED_REVERSE]                  = dir_q;
        led_vec[LED_ADDR_MSB:LED_ADDR_LSB]    = addr_q[ADDR_WIDTH-1 -: 4];
        tone_d                                = playing ? rom_data : '0;
    end

    // The >= compare lets a shortened note that already overran end on the next edge.
    always_comb begin
        dir_d  = dir_q ^ bus.reverse;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (state_q == ST_PLAY) begin
            if (cnt_q >= note_len_q - 32'd1) begin
                cnt_d  = '0;
                addr_d = dir_q ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        len_sum    = {1'b0, note_len_q} + {1'b0, STEP};
        note_len_d = note_len_q;
        if (bus.tempo_up && !bus.tempo_down) begin
            note_len_d = (note_len_q >= STEP_X2) ? note_len_q - STEP : STEP;
        end else if (bus.tempo_down && !bus.tempo_up) begin
            note_len_d = (len_sum >= {1'b0, NOTE_LEN_MAX}) ? NOTE_LEN_MAX : len_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            note_len_q <= NOTE_LEN_RST;
            tone_q     <= '0;
        end else begin
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            note_len_q <= note_len_d;
            tone_q     <= tone_d;
        end
    end

    assign bus.tone     = tone_q;
    assign bus.rom_addr = addr_q;
    assign bus.leds     = led_vec;

endmodule

// File: tb/tb_music_streamer.sv
// Directed bench for music_streamer; rom_addr steps are checked against a queue of expected
// (cycle, address) events, other outputs at fixed points.
module tb_music_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    typedef struct {
        int cyc;
        int addr;
    } step_t;

    step_t      exp_q[$];
    step_t      e;
    logic [9:0] prev_addr;

    music_streamer_if #(.ADDR_WIDTH(10)) bus ();

    music_streamer #(
        .CYCLES_PER_SECOND (400),
        .NOTE_DIV          (4),
        .TEMPO_STEP        (10),
        .ADDR_WIDTH        (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [31:0] rom_ref(input int a);
        return 32'(1000 + a * 37);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_addr = bus.rom_addr;
        end else if (bus.rom_addr !== prev_addr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'(bus.rom_addr), 32'(prev_addr));
            end else begin
                e = exp_q.pop_front();
                check("step_addr", 32'(bus.rom_addr), 32'(e.addr));
                check("step_cycle", 32'(cyc), 32'(e.cyc));
            end
            prev_addr = bus.rom_addr;
        end
    end

    task automatic goto(input int k);
        int budget;
        budget = 0;
        while (cyc < k) begin
            @(negedge clk);
            budget++;
            if (budget > 5000) begin
                $display("FAIL goto_timeout: cycle %0d target %0d", cyc, k);
                $fatal(1, "cycle budget expired");
            end
        end
    endtask

    task automatic pulse(input bit pp, input bit rv, input bit tu, input bit td);
        bus.play_pause = pp;
        bus.reverse    = rv;
        bus.tempo_up   = tu;
        bus.tempo_down = td;
        @(negedge clk);
        bus.play_pause = 1'b0;
        bus.reverse    = 1'b0;
        bus.tempo_up   = 1'b0;
        bus.tempo_down = 1'b0;
    endtask

    task automatic push(input int c, input int a);
        step_t s;
        s.cyc  = c;
        s.addr = a;
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.play_pause = 1'b0;
        bus.reverse    = 1'b0;
        bus.tempo_up   = 1'b0;
        bus.tempo_down = 1'b0;

        // Free run: reset state, steps every 100 cycles, tone 2 cycles behind the address.
        repeat (3) @(negedge clk);
        check("rst_tone", bus.tone, 32'd0);
        check("rst_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_leds", 32'(bus.leds), 32'h01);
        rst = 1'b0;
        push(100, 1); push(200, 2); push(300, 3);
        goto(2);   check("tone_after_rst", bus.tone, rom_ref(0));
        goto(101); check("tone_lag1", bus.tone, rom_ref(0));
        goto(102); check("tone_lag2", bus.tone, rom_ref(1));
        goto(302); check("tone_addr3", bus.tone, rom_ref(3));
        goto(350); check("run_q_empty", 32'(exp_q.size()), 32'd0);

        // Pause at edge 150, resume at edge 400.
        do_reset();
        push(100, 1);
        goto(149); pulse(1, 0, 0, 0);
        check("pause_led", 32'(bus.leds[0]), 32'd0);
        check("pause_tone_edge", bus.tone, rom_ref(1));
        goto(151); check("pause_tone0", bus.tone, 32'd0);
        goto(250); check("pause_addr_hold", 32'(bus.rom_addr), 32'd1);
        check("pause_tone_hold", bus.tone, 32'd0);
        push(450, 2);
        goto(399); pulse(1, 0, 0, 0);
        check("resume_tone_edge", bus.tone, 32'd0);
        goto(401); check("resume_tone", bus.tone, rom_ref(1));
        goto(460); check("pause_q_empty", 32'(exp_q.size()), 32'd0);

        // Reverse at edge 10: wrap 0 -> 1023 -> 1022.
        do_reset();
        goto(9); pulse(0, 1, 0, 0);
        check("rev_led", 32'(bus.leds[1]), 32'd1);
        push(100, 1023); push(200, 1022);
        goto(210); check("rev_leds", 32'(bus.leds), 32'h3F);
        check("rev_tone", bus.tone, rom_ref(1022));
        check("rev_q_empty", 32'(exp_q.size()), 32'd0);

        // Tempo: 12 ups saturate at 10, 2 downs give 30, both together hold.
        do_reset();
        push(39, 1); push(49, 2); push(59, 3); push(89, 4);
        push(119, 5); push(149, 6); push(179, 7);
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            goto(2 + 2 * i); pulse(0, 0, 1, 0);
        end
        check("tempo_pause_addr", 32'(bus.rom_addr), 32'd0);
        check("tempo_pause_tone", bus.tone, 32'd0);
        goto(29); pulse(1, 0, 0, 0);
        goto(59); pulse(0, 0, 0, 1);
        goto(61); pulse(0, 0, 0, 1);
        goto(124); pulse(0, 0, 1, 1);
        goto(185); check("tempo_q_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous play_pause+reverse, then asynchronous reset mid-note.
        do_reset();
        goto(49); pulse(1, 1, 0, 0);
        check("both_leds", 32'(bus.leds[1:0]), 32'd2);
        goto(69); pulse(1, 0, 0, 0);
        push(120, 1023);
        goto(125); check("both_tone", bus.tone, rom_ref(1023));
        #2 rst = 1'b1;
        #1;
        check("async_leds", 32'(bus.leds), 32'h01);
        check("async_addr", 32'(bus.rom_addr), 32'd0);
        check("async_tone", bus.tone, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(100, 1);
        goto(105); check("post_rst_addr", 32'(bus.rom_addr), 32'd1);
        check("post_rst_dir", 32'(bus.leds[1]), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
